controller_input_sync: RTL and testbench

Synchronizing, debouncing and arbitrating front end for the four player controllers on the GPIO header. Takes the raw 36-pin bus: per player, 8 switches plus 1 button. It produces a single clocked "player event" with the winning player's ID and a latched 8-bit switch snapshot. The event is held until the game CPU acknowledges it. The block replaces button-edge-clocked capture with fully synchronous logic and feeds the player-input path that drives `playerInput`, `playerInputFlag` and `switchInput`.

---
 rtl/controller_input_sync.sv | 139 +++++++++++++
 tb/tb_controller_input_sync.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controller_input_sync.sv
// Synchronizer, per-button debounce and single-event arbiter for four player controllers.
// Define CTRL_ROUND_ROBIN_EN for round-robin arbitration; otherwise player 0 has fixed top priority.
module controller_input_sync #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int DEBOUNCE_W      = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [35:0] gpins,
   input  logic        ack,
   output logic [1:0]  playerInput,
   output logic        playerInputFlag,
   output logic [7:0]  switchInput
);
   // state | meaning
   // IDLE  | no event outstanding; grant the next pending player if any
   // HOLD  | event presented to the CPU, outputs frozen until ack
   typedef enum logic {IDLE, HOLD} state_t;

   localparam logic [DEBOUNCE_W-1:0] CNT_LAST = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);

   state_t                state, state_next;
   logic [35:0]           sync1, sync2;
   logic [3:0]            btn_sync, stable, stable_prev, rise, pending, grant_oh;
   logic [7:0]            sw_sync [4];
   logic [DEBOUNCE_W-1:0] cnt [4];
   logic [1:0]            winner;
   logic                  grant;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= gpins;
         sync2 <= sync1;
      end
   end

   always_comb begin
      for (int p = 0; p < 4; p++) begin
         btn_sync[p] = sync2[9*p+8];
         sw_sync[p]  = sync2[9*p +: 8];
      end
   end

   // Counter runs only while the synced level disagrees with the accepted level.
   always_ff @(posedge clk) begin
      if (reset) begin
         stable      <= '0;
         stable_prev <= '0;
         for (int p = 0; p < 4; p++) cnt[p] <= '0;
      end else begin
         stable_prev <= stable;
         for (int p = 0; p < 4; p++) begin
            if (btn_sync[p] == stable[p]) begin
               cnt[p] <= '0;
            end else if (cnt[p] == CNT_LAST) begin
               stable[p] <= btn_sync[p];
               cnt[p]    <= '0;
            end else begin
               cnt[p] <= cnt[p] + 1'b1;
            end
         end
      end
   end

   assign rise = stable & ~stable_prev;

`ifdef CTRL_ROUND_ROBIN_EN
   logic [1:0] last_grant;
   logic [1:0] idx;
   logic       found;

   always_comb begin
      winner = 2'd0;
      idx    = 2'd0;
      found  = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         idx = last_grant + 2'(i);
         if (!found && pending[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)      last_grant <= 2'd3;
      else if (grant) last_grant <= winner;
   end
`else
   always_comb begin
      winner = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (pending[i]) winner = 2'(i);
      end
   end
`endif

   always_comb begin
      state_next = state;
      grant      = 1'b0;
      case (state)
         IDLE: begin
            if (|pending) begin
               grant      = 1'b1;
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (ack) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign grant_oh = grant ? (4'b0001 << winner) : 4'b0000;

   // A press arriving on the grant edge survives the clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         pending     <= '0;
         playerInput <= '0;
         switchInput <= '0;
      end else begin
         state   <= state_next;
         pending <= (pending & ~grant_oh) | rise;
         if (grant) begin
            playerInput <= winner;
            switchInput <= sw_sync[winner];
         end
      end
   end

   assign playerInputFlag = (state == HOLD);

endmodule

// File: tb/tb_controller_input_sync.sv
// Bench for controller_input_sync with a short debounce; directed scenarios plus a
// randomized run compared against an event-level reference model.
module tb_controller_input_sync;
   localparam int DC = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [35:0] gpins = '0;
   logic        ack = 1'b0;
   logic [1:0]  playerInput;
   logic        playerInputFlag;
   logic [7:0]  switchInput;

   int checks = 0;
   int errors = 0;

   controller_input_sync #(.DEBOUNCE_CYCLES(DC), .DEBOUNCE_W(16)) dut (
      .clk(clk), .reset(reset), .gpins(gpins), .ack(ack),
      .playerInput(playerInput), .playerInputFlag(playerInputFlag),
      .switchInput(switchInput)
   );

   always #5 clk = ~clk;

   // Reference model: pins reach the logic two edges late, a button level is accepted
   // after DC consecutive disagreeing cycles, and an accepted press queues one edge later.
   logic [35:0] m_q[$];
   logic [3:0]  m_stable = '0, m_rise_d = '0, m_pend = '0;
   int          m_run[4] = '{0, 0, 0, 0};
   bit          m_hold = 0;
   logic [1:0]  m_id = '0;
   logic [7:0]  m_sw = '0;
   int          m_last = 3;

   task automatic model_step();
      logic [35:0] syn;
      logic [3:0]  new_rise;
      logic        b;
      int          win, idx;
      if (reset) begin
         m_q.delete();
         m_q.push_back('0);
         m_q.push_back('0);
         m_stable = '0; m_rise_d = '0; m_pend = '0;
         for (int p = 0; p < 4; p++) m_run[p] = 0;
         m_hold = 0; m_id = '0; m_sw = '0; m_last = 3;
         return;
      end
      syn = m_q[0];
      void'(m_q.pop_front());
      m_q.push_back(gpins);
      new_rise = '0;
      for (int p = 0; p < 4; p++) begin
         b = syn[9*p+8];
         if (b == m_stable[p]) m_run[p] = 0;
         else begin
            m_run[p]++;
            if (m_run[p] == DC) begin
               if (b) new_rise[p] = 1'b1;
               m_stable[p] = b;
               m_run[p] = 0;
            end
         end
      end
      if (!m_hold) begin
         win = -1;
         for (int k = 0; k < 4; k++) begin
`ifdef CTRL_ROUND_ROBIN_EN
            idx = (m_last + 1 + k) % 4;
`else
            idx = k;
`endif
            if (win < 0 && m_pend[idx]) win = idx;
         end
         if (win >= 0) begin
            m_hold = 1;
            m_id = 2'(win);
            m_sw = syn[9*win +: 8];
            m_pend[win] = 1'b0;
            m_last = win;
         end
      end else if (ack) begin
         m_hold = 0;
      end
      m_pend = m_pend | m_rise_d;
      m_rise_d = new_rise;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_btn(input int p, input logic v);
      gpins[9*p+8] = v;
   endtask

   task automatic set_sw(input int p, input logic [7:0] v);
      gpins[9*p +: 8] = v;
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         gpins = {$urandom, $urandom};
         tick();
         checks++;
         if ({playerInputFlag, playerInput, switchInput} !== 11'h0) begin
            errors++;
            $display("FAIL reset_outputs: flag=%0b id=%0d sw=%h, required 0/0/00",
                     playerInputFlag, playerInput, switchInput);
         end
      end
      gpins = '0;
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (playerInputFlag !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_flag: cycle %0d flag=%0b, required 0", i, playerInputFlag);
         end
      end
   endtask

   task automatic test_latency();
      set_sw(2, 8'hA5);
      set_btn(2, 1'b1);
      for (int i = 0; i <= 7; i++) begin
         tick();
         checks++;
         if (playerInputFlag !== (i == 7)) begin
            errors++;
            $display("FAIL latency_flag: edge t0+%0d flag=%0b, required %0b", i, playerInputFlag, i == 7);
         end
      end
      checks++;
      if (playerInput !== 2'd2 || switchInput !== 8'hA5) begin
         errors++;
         $display("FAIL latency_data: id=%0d sw=%h, required 2/a5", playerInput, switchInput);
      end
      pulse_ack();
      checks++;
      if (playerInputFlag !== 1'b0 || playerInput !== 2'd2 || switchInput !== 8'hA5) begin
         errors++;
         $display("FAIL ack_release: flag=%0b id=%0d sw=%h, required 0/2/a5",
                  playerInputFlag, playerInput, switchInput);
      end
      set_btn(2, 1'b0);
      set_sw(2, 8'h00);
      settle(10);
      checks++;
      if (playerInputFlag !== 1'b0) begin
         errors++;
         $display("FAIL release_no_event: flag=%0b, required 0", playerInputFlag);
      end
   endtask

   task automatic test_glitch();
      int events;
      bit prev;
      set_btn(1, 1'b1);
      settle(3);
      set_btn(1, 1'b0);
      events = 0;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (playerInputFlag) events++;
      end
      checks++;
      if (events !== 0) begin
         errors++;
         $display("FAIL glitch_filtered: flag cycles=%0d, required 0", events);
      end
      set_btn(1, 1'b1);
      settle(5);
      set_btn(1, 1'b0);
      events = 0;
      prev = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (playerInputFlag && !prev) begin
            events++;
            checks++;
            if (playerInput !== 2'd1) begin
               errors++;
               $display("FAIL long_press_id: id=%0d, required 1", playerInput);
            end
            pulse_ack();
         end
         prev = playerInputFlag;
      end
      checks++;
      if (events !== 1) begin
         errors++;
         $display("FAIL long_press_events: events=%0d, required 1", events);
      end
   endtask

   task automatic test_arbitration();
      int n;
      logic [1:0] first, second;
`ifdef CTRL_ROUND_ROBIN_EN
      first = 2'd2; second = 2'd0;
`else
      first = 2'd0; second = 2'd2;
`endif
      set_btn(1, 1'b1);
      n = 0;
      while (!playerInputFlag && n < 20) begin tick(); n++; end
      checks++;
      if (playerInputFlag !== 1'b1 || playerInput !== 2'd1) begin
         errors++;
         $display("FAIL arb_p1_grant: flag=%0b id=%0d, required 1/1", playerInputFlag, playerInput);
      end
      pulse_ack();
      set_btn(1, 1'b0);
      settle(8);
      set_sw(0, 8'h11);
      set_sw(2, 8'h22);
      set_btn(0, 1'b1);
      set_btn(2, 1'b1);
      n = 0;
      while (!playerInputFlag && n < 20) begin tick(); n++; end
      checks++;
      if (playerInputFlag !== 1'b1 || playerInput !== first) begin
         errors++;
         $display("FAIL arb_first: flag=%0b id=%0d, required 1/%0d", playerInputFlag, playerInput, first);
      end
      pulse_ack();
      checks++;
      if (playerInputFlag !== 1'b0) begin
         errors++;
         $display("FAIL arb_gap: flag=%0b on ack edge, required 0", playerInputFlag);
      end
      tick();
      checks++;
      if (playerInputFlag !== 1'b1 || playerInput !== second) begin
         errors++;
         $display("FAIL arb_second: flag=%0b id=%0d, required 1/%0d", playerInputFlag, playerInput, second);
      end
      pulse_ack();
      set_btn(0, 1'b0);
      set_btn(2, 1'b0);
      settle(10);
   endtask

   task automatic test_hold_freeze();
      int n;
      set_sw(3, 8'h3C);
      set_btn(3, 1'b1);
      n = 0;
      while (!playerInputFlag && n < 20) begin tick(); n++; end
      checks++;
      if (playerInputFlag !== 1'b1 || playerInput !== 2'd3 || switchInput !== 8'h3C) begin
         errors++;
         $display("FAIL hold_grant: flag=%0b id=%0d sw=%h, required 1/3/3c",
                  playerInputFlag, playerInput, switchInput);
      end
      set_sw(3, 8'hFF);
      set_sw(0, 8'h5A);
      set_btn(0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (playerInputFlag !== 1'b1 || playerInput !== 2'd3 || switchInput !== 8'h3C) begin
            errors++;
            $display("FAIL hold_frozen: cycle %0d flag=%0b id=%0d sw=%h, required 1/3/3c",
                     i, playerInputFlag, playerInput, switchInput);
         end
      end
      pulse_ack();
      checks++;
      if (playerInputFlag !== 1'b0) begin
         errors++;
         $display("FAIL hold_ack: flag=%0b, required 0", playerInputFlag);
      end
      tick();
      checks++;
      if (playerInputFlag !== 1'b1 || playerInput !== 2'd0 || switchInput !== 8'h5A) begin
         errors++;
         $display("FAIL hold_next: flag=%0b id=%0d sw=%h, required 1/0/5a",
                  playerInputFlag, playerInput, switchInput);
      end
      pulse_ack();
      set_btn(0, 1'b0);
      set_btn(3, 1'b0);
      settle(10);
   endtask

   task automatic test_reset_in_hold();
      int n, events;
      set_btn(3, 1'b1);
      n = 0;
      while (!playerInputFlag && n < 20) begin tick(); n++; end
      checks++;
      if (playerInputFlag !== 1'b1) begin
         errors++;
         $display("FAIL rst_hold_grant: flag=%0b, required 1", playerInputFlag);
      end
      set_btn(1, 1'b1);
      settle(10);
      reset = 1'b1;
      set_btn(1, 1'b0);
      set_btn(3, 1'b0);
      tick();
      checks++;
      if (playerInputFlag !== 1'b0) begin
         errors++;
         $display("FAIL rst_hold_abort: flag=%0b, required 0", playerInputFlag);
      end
      reset = 1'b0;
      events = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (playerInputFlag) events++;
      end
      checks++;
      if (events !== 0) begin
         errors++;
         $display("FAIL rst_pending_dropped: flag cycles=%0d, required 0", events);
      end
      set_btn(1, 1'b1);
      n = 0;
      while (!playerInputFlag && n < 20) begin tick(); n++; end
      checks++;
      if (playerInputFlag !== 1'b1 || playerInput !== 2'd1) begin
         errors++;
         $display("FAIL rst_new_press: flag=%0b id=%0d, required 1/1", playerInputFlag, playerInput);
      end
      pulse_ack();
      set_btn(1, 1'b0);
      settle(10);
   endtask

   task automatic test_random();
      int timer[4] = '{0, 0, 0, 0};
      int grants = 0;
      for (int c = 0; c < 1500; c++) begin
         for (int p = 0; p < 4; p++) begin
            if (timer[p] > 0) begin
               timer[p]--;
               if (timer[p] == 0) set_btn(p, 1'b0);
            end else if ($urandom_range(0, 15) == 0) begin
               timer[p] = $urandom_range(1, 12);
               set_btn(p, 1'b1);
            end
            if ($urandom_range(0, 7) == 0) set_sw(p, 8'($urandom));
         end
         if (playerInputFlag) ack = ($urandom_range(0, 3) == 0);
         else ack = ($urandom_range(0, 19) == 0);
         tick();
         if (playerInputFlag) grants++;
         checks++;
         if (playerInputFlag !== m_hold || playerInput !== m_id || switchInput !== m_sw) begin
            errors++;
            $display("FAIL random_model: cycle %0d got flag=%0b id=%0d sw=%h, required %0b/%0d/%h",
                     c, playerInputFlag, playerInput, switchInput, m_hold, m_id, m_sw);
         end
      end
      ack = 1'b0;
      checks++;
      if (grants == 0) begin
         errors++;
         $display("FAIL random_activity: flag cycles=%0d, required nonzero", grants);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_glitch();
      test_arbitration();
      test_hold_freeze();
      test_reset_in_hold();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
